// File: rtl/dds_ddc_center_div_34s_16ns_18s_seq.sv
// rtl/dds_ddc_center_div_34s_16ns_18s_seq.sv - radix-2 restoring divider, signed 34b / unsigned 16b -> saturated signed 18b
// Optional feature macro: DDS_DDC_CENTER_DIV_REM_EN (signed remainder output; tied to 0 when undefined)
module dds_ddc_center_div_34s_16ns_18s_seq #(
  parameter int DIVIDEND_W = 34,
  parameter int DIVISOR_W  = 16,
  parameter int QUOT_W     = 18
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] dividend,
  input  logic        [DIVISOR_W-1:0]  divisor,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [QUOT_W-1:0]     quot,
  output logic        [DIVISOR_W:0]    rem,
  output logic                         sat,
  output logic                         dbz
);

  localparam int                    CNT_W       = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]      CNT_FIRST   = CNT_W'(DIVIDEND_W - 1);
  localparam logic [QUOT_W-1:0]     Q_MAX       = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN       = {1'b1, {(QUOT_W-1){1'b0}}};
  localparam logic [DIVIDEND_W-1:0] MAG_POS_LIM = DIVIDEND_W'(Q_MAX);
  localparam logic [DIVIDEND_W-1:0] MAG_NEG_LIM = DIVIDEND_W'(Q_MIN);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [DIVIDEND_W-1:0] r_shift;
  logic [DIVISOR_W-1:0]  r_part;
  logic [DIVISOR_W-1:0]  r_div;
  logic                  r_neg;
  logic [QUOT_W-1:0]     r_quot;
  logic                  r_sat;
  logic                  r_dbz;

  logic [DIVIDEND_W-1:0] w_abs;
  logic [DIVISOR_W:0]    w_trial;
  logic [DIVISOR_W-1:0]  w_diff;
  logic                  w_ge;
  logic [DIVISOR_W-1:0]  w_part_nxt;
  logic [DIVIDEND_W-1:0] w_q_nxt;
  logic                  w_last;
  logic [QUOT_W-1:0]     w_quot_fin;
  logic                  w_sat_fin;

  // Magnitude of -2^33 is 2^33, which still fits as an unsigned 34-bit value.
  assign w_abs      = dividend[DIVIDEND_W-1] ? (~dividend + 1'b1) : dividend;
  assign w_trial    = {r_part, r_shift[DIVIDEND_W-1]};
  assign w_ge       = (w_trial >= {1'b0, r_div});
  // Partial < divisor before the shift, so a successful subtraction always fits in DIVISOR_W bits.
  assign w_diff     = w_trial[DIVISOR_W-1:0] - r_div;
  assign w_part_nxt = w_ge ? w_diff : w_trial[DIVISOR_W-1:0];
  assign w_q_nxt    = {r_shift[DIVIDEND_W-2:0], w_ge};
  assign w_last     = (r_state == S_CALC) && (r_cnt == '0);

  // Sign application and saturation of the final quotient magnitude.
  always_comb begin
    w_quot_fin = '0;
    w_sat_fin  = 1'b0;
    if (r_dbz) begin
      w_quot_fin = r_neg ? Q_MIN : Q_MAX;
    end else if (!r_neg) begin
      if (w_q_nxt > MAG_POS_LIM) begin
        w_quot_fin = Q_MAX;
        w_sat_fin  = 1'b1;
      end else begin
        w_quot_fin = w_q_nxt[QUOT_W-1:0];
      end
    end else begin
      if (w_q_nxt > MAG_NEG_LIM) begin
        w_quot_fin = Q_MIN;
        w_sat_fin  = 1'b1;
      end else begin
        w_quot_fin = ~w_q_nxt[QUOT_W-1:0] + 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (ce) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)       w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == '0)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready)      w_state_nxt = S_IDLE;
      default:                     w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Operand capture, shift/subtract iterations and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_part  <= '0;
      r_div   <= '0;
      r_neg   <= 1'b0;
      r_quot  <= '0;
      r_sat   <= 1'b0;
      r_dbz   <= 1'b0;
    end else if (ce) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= w_abs;
            r_part  <= '0;
            r_div   <= divisor;
            r_neg   <= dividend[DIVIDEND_W-1];
            r_dbz   <= (divisor == '0);
            r_cnt   <= CNT_FIRST;
          end
        end
        S_CALC: begin
          r_shift <= w_q_nxt;
          r_part  <= w_part_nxt;
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end
          if (w_last) begin
            r_quot <= w_quot_fin;
            r_sat  <= w_sat_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign quot = r_quot;
  assign sat  = r_sat;
  assign dbz  = r_dbz;

`ifdef DDS_DDC_CENTER_DIV_REM_EN
  logic [DIVISOR_W:0] r_rem;

  // Remainder takes the dividend's sign; forced to zero on divide-by-zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem <= '0;
    end else if (ce && w_last) begin
      if (r_dbz) begin
        r_rem <= '0;
      end else if (r_neg) begin
        r_rem <= ~{1'b0, w_part_nxt} + 1'b1;
      end else begin
        r_rem <= {1'b0, w_part_nxt};
      end
    end
  end

  assign rem = r_rem;
`else
  assign rem = '0;
`endif

endmodule

// File: tb/tb_dds_ddc_center_div_34s_16ns_18s_seq.sv
// tb/tb_dds_ddc_center_div_34s_16ns_18s_seq.sv - self-checking bench for the sequential centre-path divider
module tb_dds_ddc_center_div_34s_16ns_18s_seq;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               ce = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [33:0] dividend = '0;
  logic        [15:0] divisor = '0;
  logic               in_ready;
  logic               out_valid;
  logic        [17:0] quot;
  logic        [16:0] rem;
  logic               sat;
  logic               dbz;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  dds_ddc_center_div_34s_16ns_18s_seq dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .sat       (sat),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    longint      a;
    int          b;
    logic [17:0] q;
    logic [16:0] r;
    logic        s;
    logic        z;
  } vec_t;

  vec_t dir_tbl [13] = '{
    '{64'sd1000000,        1000,  18'd1000,   17'd0,      1'b0, 1'b0},
    '{-64'sd7,             2,     18'h3FFFD,  17'h1FFFF,  1'b0, 1'b0},
    '{64'sd7,              2,     18'd3,      17'd1,      1'b0, 1'b0},
    '{64'sd8589934591,     1,     18'h1FFFF,  17'd0,      1'b1, 1'b0},
    '{-64'sd8589934592,    65535, 18'h20000,  17'h1FFFE,  1'b1, 1'b0},
    '{64'sd5,              0,     18'h1FFFF,  17'd0,      1'b0, 1'b1},
    '{-64'sd5,             0,     18'h20000,  17'd0,      1'b0, 1'b1},
    '{64'sd131071,         1,     18'h1FFFF,  17'd0,      1'b0, 1'b0},
    '{64'sd131072,         1,     18'h1FFFF,  17'd0,      1'b1, 1'b0},
    '{-64'sd131072,        1,     18'h20000,  17'd0,      1'b0, 1'b0},
    '{-64'sd131073,        1,     18'h20000,  17'd0,      1'b1, 1'b0},
    '{-64'sd262145,        2,     18'h20000,  17'h1FFFF,  1'b0, 1'b0},
    '{64'sd262145,         2,     18'h1FFFF,  17'd1,      1'b1, 1'b0}
  };

  // Reference: plain integer division (truncating), then clip to the signed 18-bit range.
  function automatic void model(input longint a, input longint b,
                                output logic [17:0] q, output logic [16:0] r,
                                output logic s, output logic z);
    longint qq;
    longint rr;
    r = '0;
    if (b == 0) begin
      z = 1'b1;
      s = 1'b0;
      q = (a >= 0) ? 18'h1FFFF : 18'h20000;
    end else begin
      qq = a / b;
      rr = a % b;
      z  = 1'b0;
      s  = 1'b0;
      if (qq > 131071) begin
        q = 18'h1FFFF;
        s = 1'b1;
      end else if (qq < -131072) begin
        q = 18'h20000;
        s = 1'b1;
      end else begin
        q = qq[17:0];
      end
`ifdef DDS_DDC_CENTER_DIV_REM_EN
      r = rr[16:0];
`endif
    end
  endfunction

  // Drives one transaction from a negedge; returns observations, callers compare.
  task automatic run_op(input logic signed [33:0] a, input logic [15:0] b,
                        input bit tog, input int hold, input bit pulse,
                        output logic [17:0] q, output logic [16:0] r,
                        output logic s, output logic z,
                        output int lat, output int lows,
                        output bit ok_busy, output bit ok_hold, output bit ok_exit,
                        output int t_acc);
    int edges;
    int w;
    ok_busy = 1'b1;
    ok_hold = 1'b1;
    ok_exit = 1'b1;
    lat     = -1;
    lows    = 0;
    t_acc   = 0;
    q = '0; r = '0; s = 1'b0; z = 1'b0;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    ce        = 1'b1;
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b0;
    @(posedge clk);
    edges = 0;
    while (edges < 200) begin
      @(negedge clk);
      if (edges == 0) t_acc = cyc;
      if (out_valid) begin
        lat = edges;
        break;
      end
      if (in_ready) ok_busy = 1'b0;
      in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pulse) begin
        dividend = 34'({$urandom(), $urandom()});
        divisor  = 16'($urandom());
      end
      ce = tog ? 1'(edges % 2 == 1) : 1'b1;
      @(posedge clk);
      edges++;
      if (!ce) lows++;
    end
    in_valid = 1'b0;
    ce       = 1'b1;
    if (lat < 0) return;
    q = quot; r = rem; s = sat; z = dbz;
    if (in_ready) ok_busy = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || in_ready || quot !== q || rem !== r || sat !== s || dbz !== z) ok_hold = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (out_valid || !in_ready) ok_exit = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", out_valid); end
    checks++; if (quot !== 18'd0) begin errors++; $display("FAIL reset quot got %h exp 0", quot); end
    checks++; if (rem !== 17'd0) begin errors++; $display("FAIL reset rem got %h exp 0", rem); end
    checks++; if (sat !== 1'b0 || dbz !== 1'b0) begin errors++; $display("FAIL reset flags got sat=%b dbz=%b exp 0 0", sat, dbz); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_release handshake got in_ready=%b out_valid=%b exp 1 0", in_ready, out_valid); end
  endtask

  task automatic test_directed;
    logic [17:0] q; logic [16:0] r; logic s, z, exp_r;
    logic [16:0] er;
    int lat, lows, t;
    bit okb, okh, oke;
    for (int i = 0; i < 13; i++) begin
      run_op(34'(dir_tbl[i].a), 16'(dir_tbl[i].b), 1'b0, 0, 1'b0, q, r, s, z, lat, lows, okb, okh, oke, t);
`ifdef DDS_DDC_CENTER_DIV_REM_EN
      er = dir_tbl[i].r;
`else
      er = '0;
`endif
      exp_r = 1'b0;
      checks++; if (lat !== 34) begin errors++; $display("FAIL dir%0d latency got %0d exp 34", i, lat); end
      checks++; if (q !== dir_tbl[i].q) begin errors++; $display("FAIL dir%0d quot got %h exp %h", i, q, dir_tbl[i].q); end
      checks++; if (r !== er) begin errors++; $display("FAIL dir%0d rem got %h exp %h", i, r, er); end
      checks++; if (s !== dir_tbl[i].s) begin errors++; $display("FAIL dir%0d sat got %b exp %b", i, s, dir_tbl[i].s); end
      checks++; if (z !== dir_tbl[i].z) begin errors++; $display("FAIL dir%0d dbz got %b exp %b", i, z, dir_tbl[i].z); end
      checks++; if (okb !== 1'b1) begin errors++; $display("FAIL dir%0d in_ready_during_calc got high exp low", i); end
      checks++; if (oke !== 1'b1) begin errors++; $display("FAIL dir%0d done_exit got bad handshake exp out_valid=0 in_ready=1", i); end
      if (exp_r) $display("unused");
    end
  endtask

  task automatic test_random;
    logic [17:0] q, eq; logic [16:0] r, er; logic s, z, es, ez;
    int lat, lows, t, mode, hold;
    bit okb, okh, oke;
    longint aa, bb;
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin aa = longint'($signed(34'({$urandom(), $urandom()}))); bb = $urandom_range(1, 65535); end
        1: begin aa = longint'($signed($urandom()) >>> $urandom_range(0, 20)); bb = $urandom_range(1, 300); end
        2: begin
          bb = $urandom_range(1, 65535);
          aa = longint'($urandom_range(131070, 131074)) * bb + longint'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) aa = -aa;
          if (aa > 64'sd8589934591) aa = 64'sd8589934591;
        end
        default: begin aa = longint'($signed(34'({$urandom(), $urandom()}))); bb = 0; end
      endcase
      hold = $urandom_range(0, 2);
      model(aa, bb, eq, er, es, ez);
      run_op(34'(aa), 16'(bb), 1'b0, hold, 1'b0, q, r, s, z, lat, lows, okb, okh, oke, t);
      checks++; if (lat !== 34) begin errors++; $display("FAIL rnd%0d latency got %0d exp 34", i, lat); end
      checks++; if (q !== eq || r !== er || s !== es || z !== ez) begin
        errors++;
        $display("FAIL rnd%0d result a=%0d b=%0d got q=%h r=%h s=%b z=%b exp q=%h r=%h s=%b z=%b", i, aa, bb, q, r, s, z, eq, er, es, ez);
      end
      checks++; if (okh !== 1'b1 || oke !== 1'b1 || okb !== 1'b1) begin errors++; $display("FAIL rnd%0d handshake got hold=%b exit=%b busy=%b exp 1 1 1", i, okh, oke, okb); end
    end
  endtask

  task automatic test_stall;
    logic [17:0] q, eq; logic [16:0] r, er; logic s, z, es, ez;
    int lat, lows, t;
    bit okb, okh, oke;
    model(-64'sd1234567, 64'sd321, eq, er, es, ez);
    run_op(-34'sd1234567, 16'd321, 1'b1, 10, 1'b1, q, r, s, z, lat, lows, okb, okh, oke, t);
    checks++; if (lows < 1) begin errors++; $display("FAIL stall ce_low_count got %0d exp >0", lows); end
    checks++; if (lat !== 34 + lows) begin errors++; $display("FAIL stall latency got %0d exp %0d", lat, 34 + lows); end
    checks++; if (q !== eq || r !== er || s !== es || z !== ez) begin errors++; $display("FAIL stall result got q=%h r=%h exp q=%h r=%h", q, r, eq, er); end
    checks++; if (okh !== 1'b1) begin errors++; $display("FAIL stall hold_stable got changed exp stable"); end
    checks++; if (okb !== 1'b1) begin errors++; $display("FAIL stall in_ready_during_calc got high exp low"); end
    checks++; if (oke !== 1'b1) begin errors++; $display("FAIL stall done_exit got bad handshake exp out_valid=0 in_ready=1"); end
  endtask

  task automatic test_back_to_back;
    logic [17:0] q; logic [16:0] r; logic s, z;
    int lat, lows, t1, t2;
    bit okb, okh, oke;
    run_op(34'sd999, 16'd10, 1'b0, 0, 1'b0, q, r, s, z, lat, lows, okb, okh, oke, t1);
    run_op(34'sd1000, 16'd10, 1'b0, 0, 1'b0, q, r, s, z, lat, lows, okb, okh, oke, t2);
    checks++; if (t2 - t1 !== 36) begin errors++; $display("FAIL b2b accept_interval got %0d exp 36", t2 - t1); end
    checks++; if (q !== 18'd100 || s !== 1'b0) begin errors++; $display("FAIL b2b quot got %h exp %h", q, 18'd100); end
  endtask

  task automatic test_reset_abort;
    logic [17:0] q; logic [16:0] r; logic s, z;
    int lat, lows, t, w;
    bit okb, okh, oke;
    w = 0;
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    ce = 1'b1; in_valid = 1'b1; dividend = 34'sd123456789; divisor = 16'd77; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (17) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort handshake got out_valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
    checks++; if (quot !== 18'd0 || rem !== 17'd0 || sat !== 1'b0 || dbz !== 1'b0) begin errors++; $display("FAIL abort outputs got q=%h r=%h s=%b z=%b exp 0", quot, rem, sat, dbz); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(34'sd3, 16'd1, 1'b0, 0, 1'b0, q, r, s, z, lat, lows, okb, okh, oke, t);
    checks++; if (lat !== 34) begin errors++; $display("FAIL abort_next latency got %0d exp 34", lat); end
    checks++; if (q !== 18'd3 || r !== 17'd0 || s !== 1'b0 || z !== 1'b0) begin errors++; $display("FAIL abort_next result got q=%h r=%h s=%b z=%b exp 3 0 0 0", q, r, s, z); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
